// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter for the 8-bit data / 16-bit address system bus.
// A grant is held until the owner drops cs; a watchdog force-terminates unacked accesses.
`timescale 1ns/1ps
module bus_arbiter #(
    parameter int         TIMEOUT  = 64,
    parameter logic [7:0] ERR_DATA = 8'hFF
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [15:0] i_m0_addr,
    input  logic [7:0]  i_m0_dat,
    input  logic        i_m0_we,
    input  logic        i_m0_cs,
    output logic [7:0]  o_m0_dat,
    output logic        o_m0_ack,
    input  logic [15:0] i_m1_addr,
    input  logic [7:0]  i_m1_dat,
    input  logic        i_m1_we,
    input  logic        i_m1_cs,
    output logic [7:0]  o_m1_dat,
    output logic        o_m1_ack,
    output logic [15:0] o_addr,
    output logic [7:0]  o_dat,
    output logic        o_we,
    output logic        o_cs,
    input  logic [7:0]  i_dat,
    input  logic        i_ack,
    output logic [1:0]  o_grant,
    output logic        o_timeout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

    state_t     r_state;
    logic       r_last;
    logic [7:0] r_wdCount;
    logic       r_armed;
    logic [1:0] r_grant;

    logic       w_ownCs;
    logic       w_fire;

    // r_armed marks the forced-termination cycle. o_cs is dropped for that whole cycle
    // (not only when i_ack stays low) so o_cs never depends combinationally on i_ack.
    always_comb begin
        w_ownCs   = 1'b0;
        w_fire    = 1'b0;
        o_addr    = 16'h0000;
        o_dat     = 8'h00;
        o_we      = 1'b0;
        o_cs      = 1'b0;
        o_m0_dat  = 8'h00;
        o_m0_ack  = 1'b0;
        o_m1_dat  = 8'h00;
        o_m1_ack  = 1'b0;
        case (r_state)
            OWN0: begin
                w_ownCs  = i_m0_cs;
                w_fire   = r_armed & ~i_ack;
                o_addr   = i_m0_addr;
                o_dat    = i_m0_dat;
                o_we     = i_m0_we;
                o_cs     = i_m0_cs & ~r_armed;
                o_m0_ack = i_ack | r_armed;
                o_m0_dat = w_fire ? ERR_DATA : i_dat;
            end
            OWN1: begin
                w_ownCs  = i_m1_cs;
                w_fire   = r_armed & ~i_ack;
                o_addr   = i_m1_addr;
                o_dat    = i_m1_dat;
                o_we     = i_m1_we;
                o_cs     = i_m1_cs & ~r_armed;
                o_m1_ack = i_ack | r_armed;
                o_m1_dat = w_fire ? ERR_DATA : i_dat;
            end
            default: begin
            end
        endcase
        o_timeout = w_fire;
        o_grant   = r_grant;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state   <= IDLE;
            r_last    <= 1'b1;
            r_wdCount <= 8'd0;
            r_armed   <= 1'b0;
            r_grant   <= 2'b00;
        end else begin
            r_armed <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_wdCount <= 8'd0;
                    if (i_m0_cs && (!i_m1_cs || r_last)) begin
                        r_state <= OWN0;
                        r_grant <= 2'b01;
                        r_last  <= 1'b0;
                    end else if (i_m1_cs) begin
                        r_state <= OWN1;
                        r_grant <= 2'b10;
                        r_last  <= 1'b1;
                    end
                end
                OWN0, OWN1: begin
                    // Past the first two branches o_cs is high and no ack has arrived.
                    if (!w_ownCs) begin
                        r_state   <= IDLE;
                        r_grant   <= 2'b00;
                        r_wdCount <= 8'd0;
                    end else if (i_ack || r_armed) begin
                        r_wdCount <= 8'd0;
                    end else if (r_wdCount == WD_LAST) begin
                        r_armed   <= 1'b1;
                        r_wdCount <= 8'd0;
                    end else begin
                        r_wdCount <= r_wdCount + 8'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_grant <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus randomized traffic,
// all compared against a cycle-level ownership/wait-count reference model.
`timescale 1ns/1ps
module tb_bus_arbiter;

    localparam int         TIMEOUT  = 64;
    localparam logic [7:0] ERR_DATA = 8'hFF;

    logic        i_clk;
    logic        i_reset_n;
    logic [15:0] i_m0_addr, i_m1_addr, o_addr;
    logic [7:0]  i_m0_dat, i_m1_dat, o_m0_dat, o_m1_dat, o_dat, i_dat;
    logic        i_m0_we, i_m0_cs, i_m1_we, i_m1_cs, o_m0_ack, o_m1_ack;
    logic        o_we, o_cs, i_ack, o_timeout;
    logic [1:0]  o_grant;

    bus_arbiter #(.TIMEOUT(TIMEOUT), .ERR_DATA(ERR_DATA)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n),
        .i_m0_addr(i_m0_addr), .i_m0_dat(i_m0_dat), .i_m0_we(i_m0_we), .i_m0_cs(i_m0_cs),
        .o_m0_dat(o_m0_dat), .o_m0_ack(o_m0_ack),
        .i_m1_addr(i_m1_addr), .i_m1_dat(i_m1_dat), .i_m1_we(i_m1_we), .i_m1_cs(i_m1_cs),
        .o_m1_dat(o_m1_dat), .o_m1_ack(o_m1_ack),
        .o_addr(o_addr), .o_dat(o_dat), .o_we(o_we), .o_cs(o_cs),
        .i_dat(i_dat), .i_ack(i_ack), .o_grant(o_grant), .o_timeout(o_timeout)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int nCompared   = 0;
    int nMismatched = 0;

    // Reference model: owner (-1 = idle), last granted master, cycles the current
    // access has waited unacked with cs high, and cycles spent in the current ownership.
    int mOwner, mLast, mWaited, mOwnCycles;

    logic [1:0]  obsGrant;
    logic        obsCs, obsTo, obsM0Ack, obsM1Ack;
    logic [15:0] obsAddr;
    logic [7:0]  obsM0Dat, obsM1Dat;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        if (obs !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s @%0t: got %0h, expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic resetModel();
        mOwner     = -1;
        mLast      = 1;
        mWaited    = 0;
        mOwnCycles = 0;
    endtask

    task automatic checkCycle();
        logic        armed, ownCs;
        logic        eCs, eWe, eTo, eM0Ack, eM1Ack;
        logic [15:0] eAddr;
        logic [7:0]  eDat, eM0Dat, eM1Dat;
        logic [1:0]  eGrant;
        int          nxt;
        eCs = 0; eWe = 0; eTo = 0; eM0Ack = 0; eM1Ack = 0;
        eAddr = 16'h0; eDat = 8'h0; eM0Dat = 8'h0; eM1Dat = 8'h0; eGrant = 2'b00;
        armed = (mOwner >= 0) && (mWaited == TIMEOUT);
        if (mOwner == 0) begin
            eGrant = 2'b01; eAddr = i_m0_addr; eDat = i_m0_dat; eWe = i_m0_we;
            eCs = i_m0_cs && !armed;
            eM0Ack = i_ack || armed;
            eM0Dat = (armed && !i_ack) ? ERR_DATA : i_dat;
            eTo = armed && !i_ack;
        end else if (mOwner == 1) begin
            eGrant = 2'b10; eAddr = i_m1_addr; eDat = i_m1_dat; eWe = i_m1_we;
            eCs = i_m1_cs && !armed;
            eM1Ack = i_ack || armed;
            eM1Dat = (armed && !i_ack) ? ERR_DATA : i_dat;
            eTo = armed && !i_ack;
        end
        checkOutput("grant", o_grant, eGrant);
        checkOutput("addr", o_addr, eAddr);
        checkOutput("wdat", o_dat, eDat);
        checkOutput("we", o_we, eWe);
        if (!(armed && i_ack)) checkOutput("cs", o_cs, eCs);
        checkOutput("timeout", o_timeout, eTo);
        checkOutput("m0ack", o_m0_ack, eM0Ack);
        checkOutput("m0dat", o_m0_dat, eM0Dat);
        checkOutput("m1ack", o_m1_ack, eM1Ack);
        checkOutput("m1dat", o_m1_dat, eM1Dat);
        obsGrant = o_grant; obsCs = o_cs; obsTo = o_timeout; obsAddr = o_addr;
        obsM0Ack = o_m0_ack; obsM0Dat = o_m0_dat; obsM1Ack = o_m1_ack; obsM1Dat = o_m1_dat;
        if (mOwner < 0) begin
            nxt = -1;
            if (i_m0_cs && i_m1_cs) nxt = 1 - mLast;
            else if (i_m0_cs)       nxt = 0;
            else if (i_m1_cs)       nxt = 1;
            if (nxt >= 0) begin
                mOwner = nxt; mLast = nxt; mWaited = 0; mOwnCycles = 0;
            end
        end else begin
            ownCs = (mOwner == 0) ? i_m0_cs : i_m1_cs;
            mOwnCycles++;
            if (!ownCs) begin
                mOwner = -1; mWaited = 0;
            end else if (armed || i_ack) begin
                mWaited = 0;
            end else begin
                mWaited++;
            end
        end
    endtask

    // Called just after a rising edge: drive one cycle of inputs, check mid-cycle, advance.
    task automatic applyStimulus(input logic c0, input logic w0, input logic [15:0] a0, input logic [7:0] d0,
                                 input logic c1, input logic w1, input logic [15:0] a1, input logic [7:0] d1,
                                 input logic ack, input logic [7:0] sd);
        i_m0_cs = c0; i_m0_we = w0; i_m0_addr = a0; i_m0_dat = d0;
        i_m1_cs = c1; i_m1_we = w1; i_m1_addr = a1; i_m1_dat = d1;
        i_ack = ack; i_dat = sd;
        #4;
        checkCycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic doReset();
        i_reset_n = 1'b0;
        i_m0_cs = 0; i_m1_cs = 0; i_ack = 0;
        @(posedge i_clk);
        #1;
        i_reset_n = 1'b1;
        resetModel();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] stopped");
    end

    initial begin
        int csRise, toCycle, pulses, ackMode;
        logic c0, c1;
        logic [1:0] runVal[$];
        int runLen[$];
        logic [1:0] expRuns[7];

        i_reset_n = 1'b0;
        i_m0_addr = 0; i_m0_dat = 0; i_m0_we = 0; i_m0_cs = 0;
        i_m1_addr = 0; i_m1_dat = 0; i_m1_we = 0; i_m1_cs = 0;
        i_dat = 0; i_ack = 0;
        resetModel();
        #12;
        checkOutput("rst_grant", o_grant, 2'b00);
        checkOutput("rst_cs", o_cs, 1'b0);
        checkOutput("rst_timeout", o_timeout, 1'b0);
        checkOutput("rst_addr", o_addr, 16'h0000);
        checkOutput("rst_m0ack", o_m0_ack, 1'b0);
        @(posedge i_clk);
        #1;
        i_reset_n = 1'b1;

        // m0 read, slave acks after two wait cycles
        applyStimulus(1, 0, 16'h1234, 8'h00, 0, 0, 16'h0, 8'h00, 0, 8'h00);
        checkOutput("t1_gnt_pre", obsGrant, 2'b00);
        applyStimulus(1, 0, 16'h1234, 8'h00, 0, 0, 16'h0, 8'h00, 0, 8'h00);
        checkOutput("t1_gnt", obsGrant, 2'b01);
        checkOutput("t1_addr", obsAddr, 16'h1234);
        applyStimulus(1, 0, 16'h1234, 8'h00, 0, 0, 16'h0, 8'h00, 0, 8'h00);
        applyStimulus(1, 0, 16'h1234, 8'h00, 0, 0, 16'h0, 8'h00, 1, 8'hA5);
        checkOutput("t1_dat", obsM0Dat, 8'hA5);
        checkOutput("t1_ack", obsM0Ack, 1'b1);
        checkOutput("t1_m1ack", obsM1Ack, 1'b0);
        applyStimulus(0, 0, 16'h0, 8'h00, 0, 0, 16'h0, 8'h00, 0, 8'h00);
        applyStimulus(0, 0, 16'h0, 8'h00, 0, 0, 16'h0, 8'h00, 0, 8'h00);
        checkOutput("t1_idle", obsGrant, 2'b00);

        // simultaneous request after reset: m0 first, then one idle cycle, then m1
        doReset();
        applyStimulus(1, 0, 16'h1111, 8'h00, 1, 0, 16'h2222, 8'h00, 0, 8'h00);
        applyStimulus(1, 0, 16'h1111, 8'h00, 1, 0, 16'h2222, 8'h00, 1, 8'h10);
        checkOutput("t2_first", obsGrant, 2'b01);
        applyStimulus(0, 0, 16'h1111, 8'h00, 1, 0, 16'h2222, 8'h00, 0, 8'h00);
        applyStimulus(0, 0, 16'h1111, 8'h00, 1, 0, 16'h2222, 8'h00, 0, 8'h00);
        checkOutput("t2_gap", obsGrant, 2'b00);
        applyStimulus(0, 0, 16'h1111, 8'h00, 1, 0, 16'h2222, 8'h00, 1, 8'h20);
        checkOutput("t2_second", obsGrant, 2'b10);
        checkOutput("t2_addr", obsAddr, 16'h2222);
        applyStimulus(0, 0, 16'h0, 8'h00, 0, 0, 16'h0, 8'h00, 0, 8'h00);
        applyStimulus(0, 0, 16'h0, 8'h00, 0, 0, 16'h0, 8'h00, 0, 8'h00);

        // continuous contention: owner drops cs after two owned cycles, re-raises next cycle
        doReset();
        for (int k = 0; k < 20; k++) begin
            c0 = !(mOwner == 0 && mOwnCycles >= 2);
            c1 = !(mOwner == 1 && mOwnCycles >= 2);
            applyStimulus(c0, 0, 16'h00A0, 8'h00, c1, 0, 16'h00B0, 8'h00, 1, 8'h33);
            if (runVal.size() > 0 && runVal[runVal.size()-1] == obsGrant)
                runLen[runLen.size()-1]++;
            else begin
                runVal.push_back(obsGrant);
                runLen.push_back(1);
            end
        end
        applyStimulus(0, 0, 16'h0, 8'h00, 0, 0, 16'h0, 8'h00, 0, 8'h00);
        applyStimulus(0, 0, 16'h0, 8'h00, 0, 0, 16'h0, 8'h00, 0, 8'h00);
        expRuns = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
        if (runVal.size() < 8) begin
            checkOutput("t3_runs", runVal.size(), 8);
        end else begin
            for (int r = 0; r < 7; r++) begin
                checkOutput("t3_grant", runVal[r+1], expRuns[r]);
                if (expRuns[r] == 2'b00) checkOutput("t3_gapLen", runLen[r+1], 1);
            end
        end

        // m1 write with no slave ack: watchdog fires TIMEOUT cycles after o_cs rises
        csRise = -1; toCycle = -1;
        for (int k = 0; k < 200 && toCycle < 0; k++) begin
            applyStimulus(0, 0, 16'h0, 8'h00, 1, 1, 16'hFA01, 8'h41, 0, 8'($urandom));
            if (obsCs && csRise < 0) csRise = k;
            if (obsTo) begin
                toCycle = k;
                checkOutput("t4_dat", obsM1Dat, 8'hFF);
                checkOutput("t4_ack", obsM1Ack, 1'b1);
                checkOutput("t4_cs", obsCs, 1'b0);
            end
        end
        if (toCycle < 0) checkOutput("t4_seen", 0, 1);
        else checkOutput("t4_latency", toCycle - csRise, TIMEOUT);
        applyStimulus(0, 0, 16'h0, 8'h00, 0, 0, 16'h0, 8'h00, 0, 8'h00);
        applyStimulus(0, 0, 16'h0, 8'h00, 0, 0, 16'h0, 8'h00, 0, 8'h00);

        // ack lands exactly on the watchdog cycle: real data wins, no pulse
        pulses = 0;
        for (int k = 0; k < 70; k++) begin
            applyStimulus(1, 0, 16'h4000, 8'h00, 0, 0, 16'h0, 8'h00, k == TIMEOUT + 1,
                          (k == TIMEOUT + 1) ? 8'h5A : 8'h00);
            if (obsTo) pulses++;
            if (k == TIMEOUT + 1) begin
                checkOutput("t5_dat", obsM0Dat, 8'h5A);
                checkOutput("t5_ack", obsM0Ack, 1'b1);
            end
        end
        checkOutput("t5_pulses", pulses, 0);
        applyStimulus(0, 0, 16'h0, 8'h00, 0, 0, 16'h0, 8'h00, 0, 8'h00);
        applyStimulus(0, 0, 16'h0, 8'h00, 0, 0, 16'h0, 8'h00, 0, 8'h00);

        // asynchronous reset in the middle of an m0 access
        applyStimulus(1, 0, 16'h5555, 8'h00, 0, 0, 16'h0, 8'h00, 0, 8'h00);
        applyStimulus(1, 0, 16'h5555, 8'h00, 0, 0, 16'h0, 8'h00, 0, 8'h00);
        #1;
        checkOutput("t6_preCs", o_cs, 1'b1);
        i_reset_n = 1'b0;
        #1;
        checkOutput("t6_rstCs", o_cs, 1'b0);
        checkOutput("t6_rstGrant", o_grant, 2'b00);
        @(posedge i_clk);
        #1;
        i_reset_n = 1'b1;
        resetModel();
        applyStimulus(1, 0, 16'h0101, 8'h00, 1, 0, 16'h0202, 8'h00, 0, 8'h00);
        applyStimulus(1, 0, 16'h0101, 8'h00, 1, 0, 16'h0202, 8'h00, 1, 8'h00);
        checkOutput("t6_tie", obsGrant, 2'b01);
        applyStimulus(0, 0, 16'h0, 8'h00, 0, 0, 16'h0, 8'h00, 0, 8'h00);

        // randomized traffic with slow, normal and absent slave acks
        c0 = 0; c1 = 0; ackMode = 1;
        for (int k = 0; k < 3000; k++) begin
            if (k % 250 == 0) ackMode = int'($urandom_range(0, 2));
            if (ackMode == 0) begin
                if ($urandom_range(0, 119) == 0) c0 = !c0;
                if ($urandom_range(0, 119) == 0) c1 = !c1;
            end else begin
                if ($urandom_range(0, 5) == 0) c0 = !c0;
                if ($urandom_range(0, 5) == 0) c1 = !c1;
            end
            applyStimulus(c0, 1'($urandom), 16'($urandom), 8'($urandom),
                          c1, 1'($urandom), 16'($urandom), 8'($urandom),
                          (ackMode == 0) ? 1'b0 :
                          (ackMode == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                          8'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master arbiter for the 8-bit data / 16-bit address system bus. It shares the single slave side (memory, UART and VGA slave decode) between master 0 (CPU shell) and master 1 (DMA / loader requester). Grants are round-robin, and a grant is held until the owning master drops its chip-select. A watchdog terminates any access that receives no slave ack within TIMEOUT cycles, so a missing ack cannot hang the bus.

## Interface
Parameters:
- TIMEOUT, 64: cycles a granted access may wait for i_ack before forced termination (range 2..255).
- ERR_DATA, 8'hFF: read data returned to the master on a forced termination.

Ports:
- i_clk, input, 1: system clock; all state changes on the rising edge.
- i_reset_n, input, 1: reset, asynchronous and active-low.
- i_m0_addr, input, 16: master 0 address.
- i_m0_dat, input, 8: master 0 write data.
- i_m0_we, input, 1: master 0 write enable.
- i_m0_cs, input, 1: master 0 request / chip-select.
- o_m0_dat, output, 8: master 0 read data.
- o_m0_ack, output, 1: master 0 acknowledge.
- i_m1_addr, i_m1_dat, i_m1_we, i_m1_cs: master 1 inputs, same widths as master 0.
- o_m1_dat, o_m1_ack: master 1 outputs, same widths as master 0.
- o_addr, output, 16: address to the slave decode.
- o_dat, output, 8: write data to the slaves.
- o_we, output, 1: write enable to the slaves.
- o_cs, output, 1: master request to the slave decode.
- i_dat, input, 8: read data from the slave mux.
- i_ack, input, 1: ack from the slave mux.
- o_grant, output, 2: one-hot current owner (bit 0 = m0, bit 1 = m1; 2'b00 = idle).
- o_timeout, output, 1: one-cycle pulse on a forced termination.

## Operation
- FSM states: IDLE, OWN0, OWN1. The register `last` records the most recently granted master.
- IDLE:
  - Only one cs high: go to that master's OWN state.
  - Both cs high: grant the master not equal to `last`.
  - No cs high: stay in IDLE.
- On entry to OWNn: set `last` to n and clear the watchdog counter.
- In OWNn:
  - Slave outputs o_addr, o_dat, o_we and o_cs are combinational copies of master n's inputs.
  - o_mn_dat = i_dat and o_mn_ack = i_ack.
  - The non-owner sees o_dat = 8'h00 and o_ack = 0.
- Leaving OWNn: the state stays OWNn while i_mn_cs = 1 and returns to IDLE on the edge where i_mn_cs = 0. No direct OWN0 to OWN1 transition exists; one IDLE cycle always separates owners.
- In IDLE: o_cs = o_we = 0, o_addr = 16'h0000, o_dat = 8'h00, both master acks = 0, both master data = 8'h00.
- Watchdog:
  - An 8-bit counter increments each cycle in OWNn while o_cs = 1 and i_ack = 0.
  - The counter clears on i_ack = 1, on entry to an OWN state, and in IDLE.
  - When the counter reaches TIMEOUT-1 with i_ack still 0, the next cycle presents o_mn_ack = 1 and o_mn_dat = ERR_DATA to the owner, and pulses o_timeout.
  - In that same cycle o_cs is forced to 0 so the slave sees the access terminate. The counter clears, and the state stays OWNn until the owner drops cs.
- Multi-cycle ownership is allowed: the owner may issue back-to-back accesses by keeping cs high and changing the address. Each access is acked by the slave independently.

## Timing
- Reset (i_reset_n = 0, asynchronous):
  - State and register values: state = IDLE, `last` = 1 (so m0 wins the first tie), counter = 0.
  - Output values: o_grant = 2'b00, o_timeout = 0, o_cs = 0, o_we = 0, o_addr = 0, o_dat = 0, all master acks = 0, all master data = 0.
  - Reset asserted mid-access drops o_cs immediately, without waiting for a clock edge.
- Grant latency: cs rising, sampled at edge k, gives OWN state and o_cs = 1 in cycle k+1. Minimum request-to-slave latency is 1 cycle.
- Slave ack passes to the owner combinationally in the same cycle; the arbiter adds no delay.
- Release: cs low at edge k gives IDLE in cycle k+1. A pending request from the other master is granted at edge k+1 and reaches the slave in cycle k+2.
- Timeout: with o_cs first high in cycle c and i_ack never asserted, the forced ack and o_timeout appear in cycle c+TIMEOUT.
- An i_ack arriving in the same cycle the watchdog would fire takes precedence: the real data is passed through and no o_timeout pulse is issued.
- o_grant is registered and matches the state.

## Test plan
- Reset, then m0 cs=1, addr=16'h1234, we=0; slave acks after 2 cycles with 8'hA5. Required: o_grant=01 one cycle after cs; o_m0_dat=A5 and o_m0_ack=1 in the ack cycle; o_m1_ack=0 throughout.
- Both cs rise at the same edge after reset. Required: m0 granted first. After m0 drops cs: one IDLE cycle, then o_grant=10 and o_addr equals m1's address.
- Alternating contention over 4 requests with both cs continuously re-raised. Required: grants alternate 01, 10, 01, 10 with exactly one IDLE cycle between each.
- m1 owns and writes addr=16'hFA01 with dat=8'h41; i_ack is tied 0 and TIMEOUT=64. Required: o_timeout pulses in cycle 64 after o_cs rose; o_m1_ack=1 with o_m1_dat=FF; o_cs=0 in that cycle.
- i_ack asserted exactly in cycle TIMEOUT. Required: real slave data returned and no o_timeout pulse.
- i_reset_n driven low mid-access while m0 owns with o_cs=1. Required: o_cs and o_grant go to 0 before the next clock edge. After release, a tie is won by m0.
